// File: rtl/int_req_collector.sv
// Interrupt request collector: synchronizes raw peripheral interrupt lines into
// the clk domain and, per source, either passes the synchronized level through
// or latches rising edges into a pending bit that holds until int_fin_i.
//
// Ports:
//   clk          system clock
//   rst_n_i      asynchronous active-low reset, synchronous release
//   irq_i        raw interrupt lines, asynchronous to clk
//   edge_mode_i  per source: 1 = rising-edge latched, 0 = level pass-through
//   int_fin_i    one-cycle per-source serviced pulse from the controller
//   ovf_clr_i    one-cycle per-source clear of the overflow flag
//   int_req_o    registered request bus (the pending bits)
//   overflow_o   registered sticky flag: edge arrived while already pending
module int_req_collector #(
    parameter int unsigned N_SRC       = 6,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n_i,
    input  logic [N_SRC-1:0] irq_i,
    input  logic [N_SRC-1:0] edge_mode_i,
    input  logic [N_SRC-1:0] int_fin_i,
    input  logic [N_SRC-1:0] ovf_clr_i,
    output logic [N_SRC-1:0] int_req_o,
    output logic [N_SRC-1:0] overflow_o
);

    localparam int unsigned LAST_STAGE = SYNC_STAGES - 1;

    logic [N_SRC-1:0] sync_q [SYNC_STAGES];
    logic [N_SRC-1:0] prev_q;
    logic [N_SRC-1:0] pend_q;
    logic [N_SRC-1:0] pend_d;
    logic [N_SRC-1:0] ovf_q;
    logic [N_SRC-1:0] ovf_d;
    logic [N_SRC-1:0] ovf_set;
    logic [N_SRC-1:0] sync;
    logic [N_SRC-1:0] rise;

    // Plain flop chain per bit; nothing between stages.
    always_ff @(posedge clk or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int s = 0; s < int'(SYNC_STAGES); s++) begin
                sync_q[s] <= '0;
            end
        end else begin
            sync_q[0] <= irq_i;
            for (int s = 1; s < int'(SYNC_STAGES); s++) begin
                sync_q[s] <= sync_q[s-1];
            end
        end
    end

    assign sync = sync_q[LAST_STAGE];
    // History resets low, so a line high at release yields exactly one rise.
    assign rise = sync & ~prev_q;

    // Per-source pending / overflow next state.
    always_comb begin
        pend_d  = pend_q;
        ovf_set = '0;
        for (int i = 0; i < int'(N_SRC); i++) begin
            if (edge_mode_i[i]) begin
                if (rise[i]) begin
                    // A fin in the same cycle services the old event, so no overflow.
                    pend_d[i]  = 1'b1;
                    ovf_set[i] = pend_q[i] & ~int_fin_i[i];
                end else if (int_fin_i[i]) begin
                    pend_d[i] = 1'b0;
                end
            end else begin
                pend_d[i] = sync[i];
            end
        end
        // Set wins over a simultaneous clear.
        ovf_d = ovf_set | (ovf_q & ~ovf_clr_i);
    end

    // State registers.
    always_ff @(posedge clk or negedge rst_n_i) begin
        if (!rst_n_i) begin
            prev_q <= '0;
            pend_q <= '0;
            ovf_q  <= '0;
        end else begin
            prev_q <= sync;
            pend_q <= pend_d;
            ovf_q  <= ovf_d;
        end
    end

    assign int_req_o  = pend_q;
    assign overflow_o = ovf_q;

endmodule

// File: tb/tb_int_req_collector.sv
// Self-checking bench for int_req_collector: directed scenarios plus random
// traffic, all compared against a cycle-level behavioural model.
module tb_int_req_collector;

    localparam int unsigned N  = 6;
    localparam int unsigned SS = 2;

    logic         clk = 1'b0;
    logic         rst_n_i = 1'b1;
    logic [N-1:0] irq_i = '0;
    logic [N-1:0] edge_mode_i = '0;
    logic [N-1:0] int_fin_i = '0;
    logic [N-1:0] ovf_clr_i = '0;
    logic [N-1:0] int_req_o;
    logic [N-1:0] overflow_o;

    int n_vec = 0;
    int n_err = 0;

    // Model: history of irq samples taken at each posedge (index 0 = newest).
    logic [N-1:0] hist [SS+1];
    logic [N-1:0] m_req;
    logic [N-1:0] m_ovf;

    int_req_collector #(.N_SRC(N), .SYNC_STAGES(SS)) dut (
        .clk         (clk),
        .rst_n_i     (rst_n_i),
        .irq_i       (irq_i),
        .edge_mode_i (edge_mode_i),
        .int_fin_i   (int_fin_i),
        .ovf_clr_i   (ovf_clr_i),
        .int_req_o   (int_req_o),
        .overflow_o  (overflow_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, want %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_clear();
        for (int j = 0; j <= int'(SS); j++) hist[j] = '0;
        m_req = '0;
        m_ovf = '0;
    endtask

    // One clock of the model, using the inputs present at this posedge.
    task automatic model_step();
        logic [N-1:0] s_now, s_old, ovs;
        s_now = hist[SS-1];   // irq as seen SS posedges ago = synchronized value
        s_old = hist[SS];
        ovs   = '0;
        for (int i = 0; i < int'(N); i++) begin
            if (edge_mode_i[i]) begin
                if (s_now[i] && !s_old[i]) begin
                    if (m_req[i] && !int_fin_i[i]) ovs[i] = 1'b1;
                    m_req[i] = 1'b1;
                end else if (int_fin_i[i]) begin
                    m_req[i] = 1'b0;
                end
            end else begin
                m_req[i] = s_now[i];
            end
            if (ovs[i])            m_ovf[i] = 1'b1;
            else if (ovf_clr_i[i]) m_ovf[i] = 1'b0;
        end
        for (int j = int'(SS); j > 0; j--) hist[j] = hist[j-1];
        hist[0] = irq_i;
    endtask

    // Called at a negedge: apply inputs, clock once, check at the next negedge.
    task automatic cyc(input logic [N-1:0] irq, input logic [N-1:0] fin, input logic [N-1:0] clr);
        irq_i     = irq;
        int_fin_i = fin;
        ovf_clr_i = clr;
        @(posedge clk);
        model_step();
        @(negedge clk);
        check("req", int_req_o, m_req);
        check("ovf", overflow_o, m_ovf);
    endtask

    task automatic do_reset(input logic [N-1:0] irq);
        irq_i     = irq;
        int_fin_i = '0;
        ovf_clr_i = '0;
        rst_n_i   = 1'b0;
        #1;
        model_clear();
        check("rst_req_now", int_req_o, 6'h00);
        check("rst_ovf_now", overflow_o, 6'h00);
        repeat (3) @(negedge clk);
        check("rst_req", int_req_o, 6'h00);
        check("rst_ovf", overflow_o, 6'h00);
        rst_n_i = 1'b1;
    endtask

    initial begin
        model_clear();
        @(negedge clk);
        do_reset(6'h00);

        // Edge capture and service on source 2.
        edge_mode_i = 6'h3F;
        cyc(6'h04, 6'h00, 6'h00);
        cyc(6'h04, 6'h00, 6'h00);
        check("edge_not_yet", int_req_o, 6'h00);
        cyc(6'h04, 6'h00, 6'h00);
        check("edge_cap", int_req_o, 6'h04);
        cyc(6'h04, 6'h00, 6'h00);
        repeat (4) cyc(6'h00, 6'h00, 6'h00);
        check("edge_hold", int_req_o, 6'h04);
        cyc(6'h00, 6'h04, 6'h00);
        check("edge_fin", int_req_o, 6'h00);

        // Level pass-through with ignored fin.
        edge_mode_i = 6'h00;
        for (int c = 0; c < 5; c++) cyc(6'h11, (c >= 2) ? 6'h11 : 6'h00, 6'h00);
        check("lvl_high", int_req_o, 6'h11);
        cyc(6'h00, 6'h11, 6'h00);
        cyc(6'h00, 6'h00, 6'h00);
        check("lvl_tail", int_req_o, 6'h11);
        cyc(6'h00, 6'h00, 6'h00);
        check("lvl_drop", int_req_o, 6'h00);

        // Overflow on source 0, then clear.
        edge_mode_i = 6'h3F;
        for (int p = 0; p < 2; p++) begin
            repeat (2) cyc(6'h01, 6'h00, 6'h00);
            repeat (3) cyc(6'h00, 6'h00, 6'h00);
        end
        check("ovf_set", overflow_o, 6'h01);
        check("ovf_req", int_req_o, 6'h01);
        cyc(6'h00, 6'h00, 6'h01);
        check("ovf_clr", overflow_o, 6'h00);

        // Overflow set and clear in the same cycle: set wins (rise seen on 3rd call).
        cyc(6'h01, 6'h00, 6'h00);
        cyc(6'h01, 6'h00, 6'h00);
        cyc(6'h00, 6'h00, 6'h01);
        check("ovf_set_wins", overflow_o, 6'h01);
        cyc(6'h00, 6'h01, 6'h01);
        check("ovf_clr2", overflow_o, 6'h00);

        // Source 5: pending, then simultaneous rise and fin.
        repeat (2) cyc(6'h20, 6'h00, 6'h00);
        repeat (3) cyc(6'h00, 6'h00, 6'h00);
        check("s5_pend", int_req_o, 6'h20);
        cyc(6'h20, 6'h00, 6'h00);
        cyc(6'h20, 6'h00, 6'h00);
        cyc(6'h00, 6'h20, 6'h00);
        check("s5_req", int_req_o, 6'h20);
        check("s5_ovf", overflow_o, 6'h00);

        // Build req = 21, then reset mid-run.
        cyc(6'h00, 6'h20, 6'h00);
        repeat (2) cyc(6'h21, 6'h00, 6'h00);
        repeat (2) cyc(6'h00, 6'h00, 6'h00);
        check("pre_rst", int_req_o, 6'h21);
        do_reset(6'h00);

        // Line high through reset release: exactly one capture.
        do_reset(6'h08);
        cyc(6'h08, 6'h00, 6'h00);
        cyc(6'h08, 6'h00, 6'h00);
        check("hi_rel_wait", int_req_o, 6'h00);
        cyc(6'h08, 6'h00, 6'h00);
        check("hi_rel_cap", int_req_o, 6'h08);
        cyc(6'h08, 6'h08, 6'h00);
        repeat (4) cyc(6'h08, 6'h00, 6'h00);
        check("hi_rel_once", int_req_o, 6'h00);

        // Random traffic; mode changes every 40 cycles.
        for (int blk = 0; blk < 10; blk++) begin
            edge_mode_i = N'($urandom);
            for (int c = 0; c < 40; c++) begin
                cyc(N'($urandom), N'($urandom & $urandom), N'($urandom & $urandom));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
